// File: rtl/lstm_seq_ctrl_if.sv
// Stream and datapath bundle between the LSTM sequencer and its neighbours:
// input samples in, cell operands out, cell results in, per-step hidden state out.
interface lstm_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
);
  logic                  x_valid;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  x_ready;

  logic [DATA_WIDTH-1:0] cell_x;
  logic [DATA_WIDTH-1:0] cell_c_in;
  logic [DATA_WIDTH-1:0] cell_h_in;
  logic [DATA_WIDTH-1:0] cell_c_out;
  logic [DATA_WIDTH-1:0] cell_h_out;

  logic                  step_valid;
  logic [DATA_WIDTH-1:0] step_h;
  logic [LEN_WIDTH-1:0]  step_idx;

  // master = sequencer side
  modport master (
    input  x_valid, x_data, cell_c_out, cell_h_out,
    output x_ready, cell_x, cell_c_in, cell_h_in, step_valid, step_h, step_idx
  );

  modport slave (
    output x_valid, x_data, cell_c_out, cell_h_out,
    input  x_ready, cell_x, cell_c_in, cell_h_in, step_valid, step_h, step_idx
  );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// Steps one LSTM cell datapath across an input sequence, holding the recurrent
// state (c, h) locally and writing back cell results after a fixed latency.
module lstm_seq_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int CELL_LAT    = 2,   // legal range 1..15
  parameter int LEN_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  seq_len,
  input  logic                  init_en,
  input  logic [DATA_WIDTH-1:0] c_init,
  input  logic [DATA_WIDTH-1:0] h_init,
  lstm_seq_ctrl_if.master       bus,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, WAIT_X, RUN, FIN} state_t;

  localparam int                   LAT_W    = 4;
  localparam logic [LAT_W-1:0]     LAT_INIT = LAT_W'(CELL_LAT);
  localparam logic [LAT_W-1:0]     LAT_ONE  = LAT_W'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  step_q, step_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic                  step_valid_q, step_valid_d;
  logic [DATA_WIDTH-1:0] step_h_q, step_h_d;
  logic [LEN_WIDTH-1:0]  step_idx_q, step_idx_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  always_comb begin
    // NOTE: every _d starts from its _q (or 0 for pulses) so no branch can infer a latch.
    state_d      = state_q;
    len_d        = len_q;
    step_d       = step_q;
    lat_d        = lat_q;
    c_d          = c_q;
    h_d          = h_q;
    x_d          = x_q;
    step_valid_d = 1'b0;
    step_h_d     = step_h_q;
    step_idx_d   = step_idx_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = seq_len;
          c_d     = init_en ? c_init : '0;
          h_d     = init_en ? h_init : '0;
          step_d  = '0;
          state_d = (seq_len != '0) ? WAIT_X : FIN;
        end
      end
      WAIT_X: begin
        if (bus.x_valid) begin
          x_d     = bus.x_data;
          lat_d   = LAT_INIT;
          state_d = RUN;
        end
      end
      RUN: begin
        lat_d = lat_q - LAT_ONE;
        // The cell outputs are valid during the cycle the counter reads 1.
        if (lat_q == LAT_ONE) begin
          c_d          = bus.cell_c_out;
          h_d          = bus.cell_h_out;
          step_valid_d = 1'b1;
          step_h_d     = bus.cell_h_out;
          step_idx_d   = step_q;
          if (step_q == len_q - LEN_ONE) begin
            state_d = FIN;
          end else begin
            step_d  = step_q + LEN_ONE;
            state_d = WAIT_X;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort drops any in-flight step: recurrent state and last result stay as they were.
    if (abort) begin
      state_d      = IDLE;
      c_d          = c_q;
      h_d          = h_q;
      step_valid_d = 1'b0;
      step_h_d     = step_h_q;
      step_idx_d   = step_idx_q;
      done_d       = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      step_q       <= '0;
      lat_q        <= '0;
      c_q          <= '0;
      h_q          <= '0;
      x_q          <= '0;
      step_valid_q <= 1'b0;
      step_h_q     <= '0;
      step_idx_q   <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q      <= state_d;
      len_q        <= len_d;
      step_q       <= step_d;
      lat_q        <= lat_d;
      c_q          <= c_d;
      h_q          <= h_d;
      x_q          <= x_d;
      step_valid_q <= step_valid_d;
      step_h_q     <= step_h_d;
      step_idx_q   <= step_idx_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.x_ready    = (state_q == WAIT_X);
  assign bus.cell_x     = x_q;
  assign bus.cell_c_in  = c_q;
  assign bus.cell_h_in  = h_q;
  assign bus.step_valid = step_valid_q;
  assign bus.step_h     = step_h_q;
  assign bus.step_idx   = step_idx_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Scoreboard bench for lstm_seq_ctrl with a one-register cell model
// (c_out = c_in + x, h_out = x) that is valid CELL_LAT-1 cycles after its inputs change.
module tb_lstm_seq_ctrl;
  localparam int DW  = 16;
  localparam int LW  = 8;
  localparam int LAT = 2;

  typedef struct packed {
    logic [DW-1:0] h;
    logic [LW-1:0] idx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          init_en = 1'b0;
  logic [LW-1:0] seq_len = '0;
  logic [DW-1:0] c_init = '0;
  logic [DW-1:0] h_init = '0;
  logic          busy, done;

  lstm_seq_ctrl_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  lstm_seq_ctrl #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .CELL_LAT(LAT), .LEN_WIDTH(LW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .seq_len (seq_len),
    .init_en (init_en),
    .c_init  (c_init),
    .h_init  (h_init),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Cell model: one register stage, so results appear exactly CELL_LAT-1 cycles late.
  logic [DW-1:0] m_c = '0, m_h = '0;
  always @(posedge clk) begin
    m_c <= bus.cell_c_in + bus.cell_x;
    m_h <= bus.cell_x;
  end
  assign bus.cell_c_out = m_c;
  assign bus.cell_h_out = m_h;

  int            checks = 0, errors = 0;
  int            cyc = 0, done_cnt = 0, done_cyc = 0, xr_cnt = 0, start_cyc = 0;
  int            step_cyc[$];
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] model_c;
  logic [LW-1:0] exp_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.x_ready) xr_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.step_valid) begin
      step_cyc.push_back(cyc);
      if (sb.size() == 0) check("unexpected_step", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("step_h", 32'(bus.step_h), 32'(mon_e.h));
        check("step_idx", 32'(bus.step_idx), 32'(mon_e.idx));
      end
    end
  end

  task automatic start_seq(input logic [LW-1:0] len, input logic ie,
                           input logic [DW-1:0] ci, input logic [DW-1:0] hi);
    @(negedge clk);
    start = 1'b1; seq_len = len; init_en = ie; c_init = ci; h_init = hi;
    start_cyc = cyc;
    model_c = ie ? ci : '0;
    exp_idx = '0;
    step_cyc.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns just after the accepting edge; x_valid is left high.
  task automatic send_x(input logic [DW-1:0] d, input bit push);
    int n = 0;
    @(negedge clk);
    bus.x_valid = 1'b1;
    bus.x_data  = d;
    while (!bus.x_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.x_ready) begin
      check("x_ready_timeout", 0, 1);
      bus.x_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) begin
      sb.push_back('{h: d, idx: exp_idx});
      model_c = model_c + d;
    end
    exp_idx++;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    check("done_seen", 32'(done), 1);
    @(negedge clk);
    check("done_pulse_width", 32'(done), 0);
    check("busy_after_done", 32'(busy), 0);
  endtask

  logic [DW-1:0] xs[3] = '{16'h0100, 16'h0200, 16'h0080};
  int d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.x_valid = 1'b0;
    bus.x_data  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_x_ready", 32'(bus.x_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_x_ready", 32'(bus.x_ready), 0);
    check("idle_step_valid", 32'(bus.step_valid), 0);
    check("idle_step_h", 32'(bus.step_h), 0);
    check("idle_step_idx", 32'(bus.step_idx), 0);
    check("idle_cell_x", 32'(bus.cell_x), 0);
    check("idle_cell_c_in", 32'(bus.cell_c_in), 0);
    check("idle_cell_h_in", 32'(bus.cell_h_in), 0);

    // Asynchronous reset in the middle of RUN
    start_seq(8'd3, 1'b1, 16'h1234, 16'h5678);
    send_x(16'h0777, 1'b0);
    @(negedge clk);
    bus.x_valid = 1'b0;
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_x_ready", 32'(bus.x_ready), 0);
    check("arst_step_valid", 32'(bus.step_valid), 0);
    check("arst_cell_x", 32'(bus.cell_x), 0);
    check("arst_cell_c_in", 32'(bus.cell_c_in), 0);
    check("arst_cell_h_in", 32'(bus.cell_h_in), 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back, seq_len=3
    start_seq(8'd3, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) send_x(xs[i], 1'b1);
    @(negedge clk);
    bus.x_valid = 1'b0;
    wait_done(50);
    check("b2b_steps", 32'(step_cyc.size()), 3);
    if (step_cyc.size() == 3) begin
      check("b2b_spacing0", 32'(step_cyc[1] - step_cyc[0]), 3);
      check("b2b_spacing1", 32'(step_cyc[2] - step_cyc[1]), 3);
      check("b2b_done_after_step", 32'(done_cyc - step_cyc[2]), 1);
    end
    check("b2b_final_c", 32'(bus.cell_c_in), 32'(model_c));
    check("b2b_final_c_abs", 32'(bus.cell_c_in), 32'h0380);

    // init_en=1, seq_len=1
    start_seq(8'd1, 1'b1, 16'h0040, 16'hFF00);
    send_x(16'h0010, 1'b1);
    @(negedge clk);
    bus.x_valid = 1'b0;
    check("init_cell_c_in", 32'(bus.cell_c_in), 32'h0040);
    check("init_cell_h_in", 32'(bus.cell_h_in), 32'hFF00);
    check("init_cell_x", 32'(bus.cell_x), 32'h0010);
    wait_done(50);
    check("init_steps", 32'(step_cyc.size()), 1);
    check("init_final_c", 32'(bus.cell_c_in), 32'(model_c));

    // seq_len=0
    d0 = xr_cnt;
    start_seq(8'd0, 1'b0, 16'h0, 16'h0);
    wait_done(10);
    check("len0_done_latency", 32'(done_cyc - start_cyc), 2);
    check("len0_no_x_ready", 32'(xr_cnt - d0), 0);
    check("len0_no_step", 32'(step_cyc.size()), 0);

    // Gapped input stream
    start_seq(8'd3, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      send_x(xs[i], 1'b1);
      @(negedge clk);
      bus.x_valid = 1'b0;
      if (i < 2) begin
        repeat (4) @(negedge clk);
        check("gap_x_ready", 32'(bus.x_ready), 1);
        check("gap_cell_x", 32'(bus.cell_x), 32'(xs[i]));
        check("gap_busy", 32'(busy), 1);
      end
    end
    wait_done(50);
    check("gap_steps", 32'(step_cyc.size()), 3);
    check("gap_final_c", 32'(bus.cell_c_in), 32'h0380);

    // start together with abort in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1; seq_len = 8'd5; init_en = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);
    @(negedge clk);
    check("start_abort_x_ready", 32'(bus.x_ready), 0);

    // Abort in the capture cycle of step 1 of 4
    start_seq(8'd4, 1'b0, 16'h0, 16'h0);
    send_x(16'h0111, 1'b1);
    @(negedge clk);
    bus.x_valid = 1'b0;
    send_x(16'h0222, 1'b0);
    @(negedge clk);
    bus.x_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_step_valid", 32'(bus.step_valid), 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 0);
    check("abort_steps", 32'(step_cyc.size()), 1);
    check("abort_keep_c", 32'(bus.cell_c_in), 32'h0111);
    check("abort_keep_h", 32'(bus.cell_h_in), 32'h0111);

    // Full sequence after abort
    start_seq(8'd4, 1'b0, 16'h0, 16'h0);
    for (int i = 1; i <= 4; i++) send_x(16'(i), 1'b1);
    @(negedge clk);
    bus.x_valid = 1'b0;
    wait_done(60);
    check("post_abort_steps", 32'(step_cyc.size()), 4);
    check("post_abort_final_c", 32'(bus.cell_c_in), 32'h000A);

    // Maximum length: no counter wrap, step_idx 0..254
    start_seq(8'd255, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 255; i++) send_x(16'(i), 1'b1);
    @(negedge clk);
    bus.x_valid = 1'b0;
    wait_done(50);
    check("max_steps", 32'(step_cyc.size()), 255);
    check("max_final_c", 32'(bus.cell_c_in), 32'(model_c));
    check("max_last_idx", 32'(bus.step_idx), 254);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lstm_seq_ctrl.md
Name: lstm_seq_ctrl

Overview:
Sequencer that steps one LSTM cell datapath across an input sequence of programmable length. It accepts input samples over a valid/ready stream and holds the recurrent state (c, h) in registers. Each timestep it presents {x, c, h} to the cell, waits a fixed cell latency, and writes the cell's c_out/h_out back. It emits a per-step hidden-state output and a completion pulse; it sits between the input stream and the lstm cell datapath.

Parameters:
DATA_WIDTH, 16, width of x/c/h words (signed Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH)
FRACT_WIDTH, 8, fractional bits; carried for consistency, no arithmetic performed here
CELL_LAT, 2, cycles from stable cell inputs to valid cell outputs; legal range 1..15
LEN_WIDTH, 8, width of sequence length and step index

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle request to begin a sequence; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
seq_len  in  LEN_WIDTH  number of timesteps, sampled on accepted start
init_en  in  1  sampled on start: 1 = load c_init/h_init, 0 = clear state to 0
c_init  in  DATA_WIDTH  initial cell state
h_init  in  DATA_WIDTH  initial hidden state
x_valid  in  1  input sample valid
x_data  in  DATA_WIDTH  input sample
x_ready  out  1  controller can accept a sample
cell_x  out  DATA_WIDTH  X to cell datapath
cell_c_in  out  DATA_WIDTH  previous cell state to datapath
cell_h_in  out  DATA_WIDTH  previous hidden state to datapath
cell_c_out  in  DATA_WIDTH  datapath new cell state
cell_h_out  in  DATA_WIDTH  datapath new hidden state
step_valid  out  1  one-cycle pulse: step result on step_h/step_idx
step_h  out  DATA_WIDTH  hidden state produced by this step
step_idx  out  LEN_WIDTH  zero-based timestep index
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when sequence completes normally

Behaviour:
- Reset (async, rst=1): state IDLE; c_reg, h_reg, x_reg, step counter, latency counter = 0; x_ready, step_valid, done, busy = 0; step_h, step_idx = 0. cell_* outputs are driven from x_reg/c_reg/h_reg and therefore read 0.
- States: IDLE, WAIT_X, RUN, FIN.
- IDLE: start=1 latches seq_len; loads c_reg/h_reg from c_init/h_init if init_en else 0; clears step counter. Next state WAIT_X if seq_len!=0, otherwise FIN (done with zero steps, no step_valid).
- WAIT_X: x_ready=1 (combinational from state). On x_valid&x_ready: x_reg<=x_data, latency counter<=CELL_LAT, next RUN. Without x_valid, remain in WAIT_X indefinitely.
- RUN: cell_x/cell_c_in/cell_h_in stay constant for the whole state. The counter decrements once per cycle. On the cycle the counter reads 1: c_reg<=cell_c_out, h_reg<=cell_h_out; step_valid pulses the next cycle with step_h=new h_reg and step_idx=current step count. If step count==len-1, next FIN, else step count+1 and next WAIT_X.
- Step timing: sample accepted at edge N, cell outputs captured at edge N+CELL_LAT, step_valid high in cycle after that edge. Minimum step period = CELL_LAT+1 cycles with x_valid held high.
- FIN: done=1 for exactly one cycle; next IDLE. busy=0 only in IDLE.
- abort has priority over every transition: next IDLE, no done, no step_valid. c_reg/h_reg keep their values; the next start reloads them. abort in IDLE has no effect.
- start outside IDLE is ignored. start together with abort in IDLE: abort wins, remain IDLE.
- seq_len=2^LEN_WIDTH-1 must complete without counter wrap; step_idx runs 0..len-1.
- Register x_ready, step_valid and done combinationally from state or as flops; they must never be high together with rst=1.

Test Plan:
- Reset mid-RUN (rst pulsed asynchronously, no clock edge) -> all outputs 0 immediately, state IDLE, next start works normally.
- seq_len=3, init_en=0, x=0x0100,0x0200,0x0080 streamed back-to-back, model cell returns c_out=c_in+x, h_out=x, CELL_LAT=2 -> step_valid at 3-cycle spacing with step_h 0x0100,0x0200,0x0080, step_idx 0,1,2; final c_reg=0x0380; done one cycle after last step_valid.
- init_en=1, c_init=0x0040, h_init=0xFF00, seq_len=1 -> first cycle of RUN shows cell_c_in=0x0040, cell_h_in=0xFF00; one step_valid, then done.
- seq_len=0 start -> done two cycles after start, no x_ready pulse, no step_valid.
- x_valid gapped by 5 idle cycles between samples -> controller waits in WAIT_X with x_ready=1, cell inputs unchanged, step results identical to back-to-back case.
- abort asserted in the CELL_LAT cycle of step 1 of 4 -> no step_valid for that step, no done, busy=0 next cycle; a following start runs a full sequence correctly.
